peak_meter: RTL and testbench

Parametrised multi-channel level meter for the display path, successor to the per-frame instrument intensity tracker. It accumulates true-magnitude peaks of signed audio samples over a display frame, then walks the channels with a small FSM. Per channel it scales and saturates the peak, and applies window or decay ballistics and optional peak-hold. Results are committed atomically with a one-cycle valid strobe. Everything runs on `clk_100MHz`; the frame strobe is already synchronised into that domain upstream.

---
 rtl/peak_meter_pkg.sv | 25 ++
 rtl/peak_meter_chan_update.sv | 77 +++++++
 rtl/peak_meter.sv | 176 +++++++++++++++++
 tb/tb_peak_meter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peak_meter_pkg.sv
// peak_meter_pkg: shared types and helpers for the peak_meter display path.
//   state_t : frame-walk FSM states (IDLE, UPDATE, COMMIT)
//   decay() : one frame of level decay, x - (x >> sh), with a guaranteed
//             step of at least one count for any non-zero x.
package peak_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    COMMIT
  } state_t;

  // Computed at 32 bits; callers truncate back to their own width.
  // The result is never wider than x, so truncation cannot lose information.
  function automatic logic [31:0] decay(input logic [31:0] x, input int unsigned sh);
    logic [31:0] d;
    d = x - (x >> sh);
    // Small values shift to zero and would never move; force a unit step.
    if ((d == x) && (x != '0)) begin
      d = x - 32'd1;
    end
    return d;
  endfunction

endpackage

// File: rtl/peak_meter_chan_update.sv
// peak_meter_chan_update: combinational per-channel frame update.
// Scales and saturates a frame peak, then applies window or decay ballistics
// to the level and, when PEAK_METER_HOLD_EN is defined, peak-hold to the peak.
// Ports:
//   snap      in  frame peak magnitude
//   level_old in  currently displayed level
//   peak_old  in  currently displayed peak   (PEAK_METER_HOLD_EN only)
//   cnt_old   in  hold counter               (PEAK_METER_HOLD_EN only)
//   mode      in  0 = window max, 1 = decay ballistics
//   level_new out updated level
//   peak_new  out updated peak (equals level_new without hold)
//   cnt_new   out updated hold counter       (PEAK_METER_HOLD_EN only)
// Macro: PEAK_METER_HOLD_EN enables peak-hold.
module peak_meter_chan_update
  import peak_meter_pkg::*;
#(
  parameter int unsigned SNAP_W      = 16,
  parameter int unsigned OUT_W       = 8,
  parameter int unsigned SHIFT       = 4,
  parameter int unsigned DECAY_SHIFT = 3
`ifdef PEAK_METER_HOLD_EN
  ,
  parameter int unsigned HOLD_FRAMES = 15,
  parameter int unsigned CNT_W       = 4
`endif
) (
  input  logic [SNAP_W-1:0] snap,
  input  logic [OUT_W-1:0]  level_old,
`ifdef PEAK_METER_HOLD_EN
  input  logic [OUT_W-1:0]  peak_old,
  input  logic [CNT_W-1:0]  cnt_old,
  output logic [CNT_W-1:0]  cnt_new,
`endif
  input  logic              mode,
  output logic [OUT_W-1:0]  level_new,
  output logic [OUT_W-1:0]  peak_new
);

  localparam logic [31:0] S_MAX = 32'((64'd1 << OUT_W) - 64'd1);

  logic [31:0]      scaled_full;
  logic [OUT_W-1:0] s;
  logic [OUT_W-1:0] level_dec;

  assign scaled_full = 32'(snap) >> SHIFT;
  assign s           = (scaled_full > S_MAX) ? '1 : scaled_full[OUT_W-1:0];
  assign level_dec   = OUT_W'(decay(32'(level_old), DECAY_SHIFT));

  always_comb begin
    level_new = s;
    if (mode && (level_dec > s)) begin
      level_new = level_dec;
    end
  end

`ifdef PEAK_METER_HOLD_EN
  logic [OUT_W-1:0] peak_dec;

  assign peak_dec = OUT_W'(decay(32'(peak_old), DECAY_SHIFT));

  always_comb begin
    peak_new = peak_old;
    cnt_new  = cnt_old;
    if (s >= peak_old) begin
      peak_new = s;
      cnt_new  = CNT_W'(HOLD_FRAMES);
    end else if (cnt_old != '0) begin
      cnt_new = cnt_old - 1'b1;
    end else begin
      peak_new = (s > peak_dec) ? s : peak_dec;
    end
  end
`else
  assign peak_new = level_new;
`endif

endmodule

// File: rtl/peak_meter.sv
// peak_meter: multi-channel level meter for the display path.
// Accumulates per-channel true-magnitude peaks over a display frame. On an
// accepted frame_tick the peaks are snapshotted and a small FSM walks the
// channels (one per cycle) through peak_meter_chan_update into shadow
// registers, which are committed together with a one-cycle level_valid.
// Ports:
//   clk_100MHz   in  system clock
//   rst_n        in  asynchronous active-low reset
//   sample_valid in  qualifies samples
//   samples      in  CHANNELS signed samples
//   frame_tick   in  single-cycle frame boundary pulse
//   mode         in  0 = window max, 1 = decay; latched on accepted tick
//   level        out CHANNELS meter levels
//   peak         out CHANNELS held peaks
//   level_valid  out one-cycle commit strobe
//   overrun      out sticky: frame_tick seen while busy
// Macro: PEAK_METER_HOLD_EN enables per-channel peak-hold counters.
module peak_meter
  import peak_meter_pkg::*;
#(
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned SAMPLE_W    = 16,
  parameter int unsigned OUT_W       = 8,
  parameter int unsigned SHIFT       = 4,
  parameter int unsigned DECAY_SHIFT = 3,
  parameter int unsigned HOLD_FRAMES = 15
) (
  input  logic                       clk_100MHz,
  input  logic                       rst_n,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] samples [CHANNELS],
  input  logic                       frame_tick,
  input  logic                       mode,
  output logic        [OUT_W-1:0]    level [CHANNELS],
  output logic        [OUT_W-1:0]    peak  [CHANNELS],
  output logic                       level_valid,
  output logic                       overrun
);

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);
  localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] MOST_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};

  state_t              state;
  logic [CH_W-1:0]     ch;
  logic                mode_q;
  logic [SAMPLE_W-1:0] mag          [CHANNELS];
  logic [SAMPLE_W-1:0] acc          [CHANNELS];
  logic [SAMPLE_W-1:0] snap         [CHANNELS];
  logic [OUT_W-1:0]    shadow_level [CHANNELS];
  logic [OUT_W-1:0]    shadow_peak  [CHANNELS];
  logic [OUT_W-1:0]    upd_level;
  logic [OUT_W-1:0]    upd_peak;
  logic                accept;

  assign accept = (state == IDLE) && frame_tick;

  // True magnitude; the most negative code has no positive twin and saturates.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      mag[i] = samples[i];
      if (samples[i][SAMPLE_W-1]) begin
        if (samples[i] == MOST_NEG) begin
          mag[i] = MOST_POS;
        end else begin
          mag[i] = ~samples[i] + 1'b1;
        end
      end
    end
  end

`ifdef PEAK_METER_HOLD_EN
  localparam int unsigned CNT_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  logic [CNT_W-1:0] cnt [CHANNELS];
  logic [CNT_W-1:0] upd_cnt;
`endif

  // Old level/peak come from the committed outputs: nothing commits between
  // the snapshot and the end of the walk, so they equal the shadow copies.
  peak_meter_chan_update #(
    .SNAP_W      (SAMPLE_W),
    .OUT_W       (OUT_W),
    .SHIFT       (SHIFT),
    .DECAY_SHIFT (DECAY_SHIFT)
`ifdef PEAK_METER_HOLD_EN
    ,
    .HOLD_FRAMES (HOLD_FRAMES),
    .CNT_W       (CNT_W)
`endif
  ) u_chan_update (
    .snap      (snap[ch]),
    .level_old (level[ch]),
`ifdef PEAK_METER_HOLD_EN
    .peak_old  (peak[ch]),
    .cnt_old   (cnt[ch]),
    .cnt_new   (upd_cnt),
`endif
    .mode      (mode_q),
    .level_new (upd_level),
    .peak_new  (upd_peak)
  );

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ch          <= '0;
      mode_q      <= 1'b0;
      level_valid <= 1'b0;
      overrun     <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        acc[i]          <= '0;
        snap[i]         <= '0;
        shadow_level[i] <= '0;
        shadow_peak[i]  <= '0;
        level[i]        <= '0;
        peak[i]         <= '0;
`ifdef PEAK_METER_HOLD_EN
        cnt[i]          <= '0;
`endif
      end
    end else begin
      level_valid <= 1'b0;

      if (frame_tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      // A sample coinciding with an accepted tick opens the new window.
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (accept) begin
          acc[i] <= sample_valid ? mag[i] : '0;
        end else if (sample_valid && (mag[i] > acc[i])) begin
          acc[i] <= mag[i];
        end
      end

      case (state)
        IDLE: begin
          if (frame_tick) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
              snap[i] <= acc[i];
            end
            mode_q <= mode;
            ch     <= '0;
            state  <= UPDATE;
          end
        end
        UPDATE: begin
          shadow_level[ch] <= upd_level;
          shadow_peak[ch]  <= upd_peak;
`ifdef PEAK_METER_HOLD_EN
          cnt[ch]          <= upd_cnt;
`endif
          if (ch == LAST_CH) begin
            ch    <= '0;
            state <= COMMIT;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        COMMIT: begin
          for (int unsigned i = 0; i < CHANNELS; i++) begin
            level[i] <= shadow_level[i];
            peak[i]  <= shadow_peak[i];
          end
          level_valid <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peak_meter.sv
module tb_peak_meter;

  localparam int CH = 3;
  localparam int SW = 16;
  localparam int OW = 8;
  localparam int SH = 4;
  localparam int DS = 3;
  localparam int HF = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 sample_valid;
  logic signed [SW-1:0] samples [CH];
  logic                 frame_tick;
  logic                 mode;
  logic        [OW-1:0] level [CH];
  logic        [OW-1:0] peak  [CH];
  logic                 level_valid;
  logic                 overrun;

  peak_meter #(
    .CHANNELS    (CH),
    .SAMPLE_W    (SW),
    .OUT_W       (OW),
    .SHIFT       (SH),
    .DECAY_SHIFT (DS),
    .HOLD_FRAMES (HF)
  ) dut (
    .clk_100MHz   (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .samples      (samples),
    .frame_tick   (frame_tick),
    .mode         (mode),
    .level        (level),
    .peak         (peak),
    .level_valid  (level_valid),
    .overrun      (overrun)
  );

  // ---------------- reference model (frame-level) ----------------
  int m_acc   [CH];
  int m_level [CH];
  int m_peak  [CH];
  int m_cnt   [CH];
  int p_level [CH];
  int p_peak  [CH];
  int p_cnt   [CH];
  int cyc;
  int commit_at;
  bit m_valid;
  bit m_overrun;
  bit running;
  int errors;
  int checks;

  function automatic int f_mag(input logic [15:0] x);
    int v;
    v = int'($signed(x));
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  function automatic int f_scale(input int a);
    int v;
    v = a / (1 << SH);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int f_decay(input int x);
    int d;
    d = x - x / (1 << DS);
    if (d == x && x != 0) d = x - 1;
    return d;
  endfunction

  function automatic int f_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_acc[k] = 0; m_level[k] = 0; m_peak[k] = 0; m_cnt[k] = 0;
    end
    commit_at = -1;
    m_valid   = 0;
    m_overrun = 0;
  endtask

  // Called right after a rising edge with the inputs that edge sampled.
  task automatic model_edge();
    bit busy;
    int s;
    cyc++;
    m_valid = 0;
    busy = (commit_at >= 0);
    if (cyc == commit_at) begin
      for (int k = 0; k < CH; k++) begin
        m_level[k] = p_level[k]; m_peak[k] = p_peak[k]; m_cnt[k] = p_cnt[k];
      end
      m_valid   = 1;
      commit_at = -1;
    end
    if (frame_tick && busy) m_overrun = 1;
    if (frame_tick && !busy) begin
      for (int k = 0; k < CH; k++) begin
        s = f_scale(m_acc[k]);
        p_level[k] = mode ? f_max(s, f_decay(m_level[k])) : s;
`ifdef PEAK_METER_HOLD_EN
        if (s >= m_peak[k]) begin
          p_peak[k] = s; p_cnt[k] = HF;
        end else if (m_cnt[k] != 0) begin
          p_peak[k] = m_peak[k]; p_cnt[k] = m_cnt[k] - 1;
        end else begin
          p_peak[k] = f_max(s, f_decay(m_peak[k])); p_cnt[k] = 0;
        end
`else
        p_peak[k] = p_level[k];
        p_cnt[k]  = 0;
`endif
        m_acc[k] = sample_valid ? f_mag(samples[k]) : 0;
      end
      commit_at = cyc + CH + 1;
    end else if (sample_valid) begin
      for (int k = 0; k < CH; k++) m_acc[k] = f_max(m_acc[k], f_mag(samples[k]));
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (running) begin
      chk("level_valid", int'(level_valid), int'(m_valid));
      chk("overrun", int'(overrun), int'(m_overrun));
      for (int k = 0; k < CH; k++) begin
        chk($sformatf("level[%0d]", k), int'(level[k]), m_level[k]);
        chk($sformatf("peak[%0d]", k), int'(peak[k]), m_peak[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit sv, input logic [15:0] s0, input logic [15:0] s1,
                      input logic [15:0] s2, input bit tick, input bit md);
    sample_valid = sv;
    samples[0]   = s0;
    samples[1]   = s1;
    samples[2]   = s2;
    frame_tick   = tick;
    mode         = md;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  // Accepted tick then wait until the commit cycle (T+CH+1).
  task automatic frame(input bit md);
    step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, md);
    idle(CH + 1);
    chk("commit strobe", int'(level_valid), 1);
  endtask

  task automatic pulse_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < CH; k++) begin
      chk($sformatf("async reset level[%0d]", k), int'(level[k]), 0);
      chk($sformatf("async reset peak[%0d]", k), int'(peak[k]), 0);
    end
    chk("async reset overrun", int'(overrun), 0);
    chk("async reset level_valid", int'(level_valid), 0);
    #1;
    rst_n = 1'b1;
  endtask

  logic [15:0] rs [CH];
  int          sel;

  initial begin
    errors = 0; checks = 0; cyc = 0; running = 0;
    model_reset();
    rst_n = 1'b0; sample_valid = 1'b0; frame_tick = 1'b0; mode = 1'b0;
    for (int k = 0; k < CH; k++) samples[k] = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    running = 1;
    chk("reset level[0]", int'(level[0]), 0);
    chk("reset level_valid", int'(level_valid), 0);

    // Window mode, single channel.
    step(1'b1, 16'h0800, 16'h0, 16'h0, 1'b0, 1'b0);
    frame(1'b0);
    chk("A level[0]", int'(level[0]), 8'h80);
    chk("A level[1]", int'(level[1]), 0);
    chk("A level[2]", int'(level[2]), 0);

    // Saturating magnitude and small negative sample.
    step(1'b1, 16'h0, 16'h8000, 16'hFFF0, 1'b0, 1'b0);
    frame(1'b0);
    chk("B level[0]", int'(level[0]), 0);
    chk("B level[1]", int'(level[1]), 8'hFF);
    chk("B level[2]", int'(level[2]), 8'h01);

    // Overrun: tick at T with a sample, second tick at T+2.
    step(1'b1, 16'h0300, 16'h0, 16'h0, 1'b1, 1'b0);
    idle(1);
    step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("overrun set", int'(overrun), 1);
    idle(2);
    chk("overrun strobe", int'(level_valid), 1);
    chk("overrun level[1]", int'(level[1]), 0);
    idle(1);
    chk("single strobe", int'(level_valid), 0);
    frame(1'b0);
    chk("carried sample", int'(level[0]), 8'h30);

    // Reset in the middle of an update.
    step(1'b1, 16'h0800, 16'h8000, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    idle(2);
    pulse_reset();
    idle(CH + 2);

    // Decay ballistics (and hold, when built in).
    step(1'b1, 16'h0800, 16'h0, 16'h0, 1'b0, 1'b0);
    frame(1'b1);
    chk("D0 level", int'(level[0]), 8'h80);
    chk("D0 peak", int'(peak[0]), 8'h80);
    frame(1'b1);
    chk("D1 level", int'(level[0]), 8'h70);
`ifdef PEAK_METER_HOLD_EN
    chk("D1 peak", int'(peak[0]), 8'h80);
`else
    chk("D1 peak", int'(peak[0]), 8'h70);
`endif
    frame(1'b1);
    chk("D2 level", int'(level[0]), 8'h62);
`ifdef PEAK_METER_HOLD_EN
    chk("D2 peak", int'(peak[0]), 8'h80);
`else
    chk("D2 peak", int'(peak[0]), 8'h62);
`endif
    frame(1'b1);
    chk("D3 level", int'(level[0]), 8'h56);
`ifdef PEAK_METER_HOLD_EN
    chk("D3 peak", int'(peak[0]), 8'h70);
`else
    chk("D3 peak", int'(peak[0]), 8'h56);
`endif

    // Minimum decay step.
    step(1'b1, 16'h0050, 16'h0, 16'h0, 1'b0, 1'b0);
    frame(1'b0);
    chk("E level 5", int'(level[0]), 8'h05);
    frame(1'b1);
    chk("E level 4", int'(level[0]), 8'h04);

    // Randomised traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < CH; k++) begin
        sel = $urandom_range(0, 9);
        case (sel)
          0:       rs[k] = 16'h8000;
          1:       rs[k] = 16'h7FFF;
          2:       rs[k] = 16'h0000;
          3:       rs[k] = 16'(-$urandom_range(1, 64));
          4:       rs[k] = 16'($urandom_range(0, 4095));
          default: rs[k] = 16'($urandom);
        endcase
      end
      step($urandom_range(0, 3) != 0, rs[0], rs[1], rs[2],
           $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
      if (n == 700) pulse_reset();
    end

    idle(CH + 2);
    running = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
